imem_arbiter: RTL and testbench

Shares the single-port instruction memory between the instruction-fetch stage and the program loader/debug port. Fetch has priority; the loader gets access through a lockable burst mode and, optionally, a starvation guarantee. It issues one memory access per cycle, returns read data one cycle later, and sits between the IF stage and instruction memory.

---
 rtl/imem_arbiter.sv | 142 ++++++++++++++
 tb/tb_imem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch has priority, loader gets lockable bursts.
// Define IMEM_ARB_STARVE_EN to add the loader starvation guarantee (STARVE_LIMIT).
module imem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [31:0]   f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [AW-1:0] l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_valid,
  output logic [31:0]   l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("imem_arbiter: STARVE_LIMIT must be in 1..255");
  end

  state_t        state_r;
  logic          starve_s;
  logic          rd_f_r;
  logic          rd_l_r;
  logic [31:0]   f_hold_r;
  logic [31:0]   l_hold_r;

`ifdef IMEM_ARB_STARVE_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt_r;

  assign starve_s = (starve_cnt_r == LIMIT);

  // Count consecutive denied loader cycles, saturating at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 8'd0;
    end else if (l_gnt) begin
      starve_cnt_r <= 8'd0;
    end else if (l_req && (starve_cnt_r != LIMIT)) begin
      starve_cnt_r <= starve_cnt_r + 8'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  assign starve_s = 1'b0;
`endif

  // Grant decision from requests and registered state
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (reset) begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
    end else if (state_r == LOCK) begin
      l_gnt = l_req;
    end else if (starve_s && l_req) begin
      l_gnt = 1'b1;
    end else if (f_req) begin
      f_gnt = 1'b1;
    end else begin
      l_gnt = l_req;
    end
  end

  // Memory port drive; idle cycles present an all-zero bus
  always_comb begin
    m_en    = f_gnt | l_gnt;
    m_we    = l_gnt & l_we;
    m_addr  = {AW{1'b0}};
    m_wdata = 32'h0000_0000;
    if (f_gnt) begin
      m_addr = f_addr & WORD_MASK;
    end else if (l_gnt) begin
      m_addr  = l_addr & WORD_MASK;
      m_wdata = l_we ? l_wdata : 32'h0000_0000;
    end else begin
      m_addr  = {AW{1'b0}};
      m_wdata = 32'h0000_0000;
    end
  end

  // Lock state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    state_r <= (l_gnt && l_lock) ? LOCK : IDLE;
        LOCK:    state_r <= l_lock ? LOCK : IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Owner tag for the read issued this cycle; reset drops any pending return
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_f_r <= 1'b0;
      rd_l_r <= 1'b0;
    end else begin
      rd_f_r <= f_gnt;
      rd_l_r <= l_gnt & ~l_we;
    end
  end

  assign f_valid = rd_f_r & ~reset;
  assign l_valid = rd_l_r & ~reset;

  // Remember the last returned word so the unselected side holds steady
  always_ff @(posedge clk) begin
    if (reset) begin
      f_hold_r <= 32'h0000_0000;
      l_hold_r <= 32'h0000_0000;
    end else begin
      f_hold_r <= f_valid ? m_rdata : f_hold_r;
      l_hold_r <= l_valid ? m_rdata : l_hold_r;
    end
  end

  assign f_rdata = reset ? 32'h0000_0000 : (f_valid ? m_rdata : f_hold_r);
  assign l_rdata = reset ? 32'h0000_0000 : (l_valid ? m_rdata : l_hold_r);

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter with a synchronous-read memory model
// and per-requester scoreboards of expected read returns.
module tb_imem_arbiter;

  localparam int AW  = 32;
  localparam int LIM = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, l_req, l_we, l_lock;
  logic [AW-1:0] f_addr, l_addr;
  logic [31:0]   l_wdata;
  logic          f_gnt, f_valid, l_gnt, l_valid;
  logic [31:0]   f_rdata, l_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        f_q[$];
  exp_t        l_q[$];
  exp_t        e;
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] fa      [0:3];
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.STARVE_LIMIT(LIM), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_valid(l_valid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Synchronous single-port memory: read data appears the cycle after the access
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[7:2]] <= m_wdata;
      else      m_rdata <= mem[m_addr[7:2]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop expected returns as the DUT produces them; also check exclusion
  always @(negedge clk) begin
    #2;
    n_cmp++;
    if (f_gnt && l_gnt) begin
      n_err++;
      $display("FAIL mutex cyc=%0d: f_gnt=%b l_gnt=%b, required not both 1", cyc, f_gnt, l_gnt);
    end
    if (f_valid) begin
      n_cmp++;
      if (f_q.size() == 0) begin
        n_err++;
        $display("FAIL f_valid_unexpected cyc=%0d: f_valid=1 data=%h, required no return", cyc, f_rdata);
      end else begin
        e = f_q.pop_front();
        if (f_rdata !== e.data || cyc !== e.due) begin
          n_err++;
          $display("FAIL f_return: got %h at cyc %0d, required %h at cyc %0d", f_rdata, cyc, e.data, e.due);
        end
      end
    end else if (f_q.size() > 0 && f_q[0].due <= cyc) begin
      n_cmp++; n_err++;
      $display("FAIL f_return_missing cyc=%0d: f_valid=0, required %h", cyc, f_q[0].data);
      void'(f_q.pop_front());
    end
    if (l_valid) begin
      n_cmp++;
      if (l_q.size() == 0) begin
        n_err++;
        $display("FAIL l_valid_unexpected cyc=%0d: l_valid=1 data=%h, required no return", cyc, l_rdata);
      end else begin
        e = l_q.pop_front();
        if (l_rdata !== e.data || cyc !== e.due) begin
          n_err++;
          $display("FAIL l_return: got %h at cyc %0d, required %h at cyc %0d", l_rdata, cyc, e.data, e.due);
        end
      end
    end else if (l_q.size() > 0 && l_q[0].due <= cyc) begin
      n_cmp++; n_err++;
      $display("FAIL l_return_missing cyc=%0d: l_valid=0, required %h", cyc, l_q[0].data);
      void'(l_q.pop_front());
    end
  end

  task automatic test_reset();
    reset = 1'b1; f_req = 1'b1; l_req = 1'b1; l_lock = 1'b1; l_we = 1'b0;
    f_addr = 32'h0; l_addr = 32'h20; l_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({f_gnt, l_gnt, m_en, f_valid, l_valid} !== 5'b0 || f_rdata !== 32'h0 || l_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL reset_outputs %0d: gnt=%b%b m_en=%b valid=%b%b rdata=%h/%h, required all 0",
                 i, f_gnt, l_gnt, m_en, f_valid, l_valid, f_rdata, l_rdata);
      end
    end
    @(negedge clk);
    reset = 1'b0; l_lock = 1'b0;
    #1;
    n_cmp++;
    if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL first_grant: f_gnt=%b l_gnt=%b, required 1/0", f_gnt, l_gnt);
    end
    f_q.push_back('{cyc + 1, ref_mem[0]});
    @(negedge clk);
    f_req = 1'b0; l_req = 1'b0;
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      f_req = 1'b1; f_addr = fa[i];
      #1;
      n_cmp++;
      if (f_gnt !== 1'b1 || m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== (fa[i] & 32'hFFFF_FFFC)) begin
        n_err++;
        $display("FAIL fetch_drive addr=%h: f_gnt=%b m_en=%b m_we=%b m_addr=%h, required 1/1/0/%h",
                 fa[i], f_gnt, m_en, m_we, m_addr, fa[i] & 32'hFFFF_FFFC);
      end
      f_q.push_back('{cyc + 1, ref_mem[fa[i][7:2]]});
    end
    @(negedge clk);
    f_req = 1'b0;
  endtask

  task automatic test_starvation();
    logic exp_l;
    @(negedge clk);
    reset = 1'b1; f_req = 1'b0; l_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        reset = 1'b0; f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; l_lock = 1'b0;
        f_addr = 32'h8; l_addr = 32'h20;
      end
      #1;
`ifdef IMEM_ARB_STARVE_EN
      exp_l = ((i % (LIM + 1)) == LIM);
`else
      exp_l = 1'b0;
`endif
      n_cmp++;
      if (l_gnt !== exp_l || f_gnt !== ~exp_l) begin
        n_err++;
        $display("FAIL starve cycle %0d: f_gnt=%b l_gnt=%b, required %b/%b", i, f_gnt, l_gnt, ~exp_l, exp_l);
      end
      if (exp_l) l_q.push_back('{cyc + 1, ref_mem[8]});
      else       f_q.push_back('{cyc + 1, ref_mem[2]});
    end
    @(negedge clk);
    f_req = 1'b0; l_req = 1'b0;
  endtask

  task automatic test_locked_burst();
    @(negedge clk);
    f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1;
    l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (l_gnt !== 1'b1 || f_gnt !== 1'b0 || m_we !== 1'b1 || m_addr !== 32'h10 || m_wdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL lock_write: l_gnt=%b f_gnt=%b m_we=%b m_addr=%h m_wdata=%h, required 1/0/1/10/deadbeef",
               l_gnt, f_gnt, m_we, m_addr, m_wdata);
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h0; l_req = 1'b0; l_we = 1'b0;
    #1;
    n_cmp++;
    if (f_gnt !== 1'b0 || l_gnt !== 1'b0 || m_en !== 1'b0 || m_addr !== 32'h0) begin
      n_err++;
      $display("FAIL lock_hold: f_gnt=%b l_gnt=%b m_en=%b m_addr=%h, required 0/0/0/0", f_gnt, l_gnt, m_en, m_addr);
    end
    @(negedge clk);
    l_req = 1'b1; l_lock = 1'b0;
    #1;
    n_cmp++;
    if (l_gnt !== 1'b1 || f_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL lock_release_read: f_gnt=%b l_gnt=%b, required 0/1", f_gnt, l_gnt);
    end
    l_q.push_back('{cyc + 1, ref_mem[4]});
    @(negedge clk);
    l_req = 1'b0;
    #1;
    n_cmp++;
    if (f_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_after_lock: f_gnt=%b, required 1", f_gnt);
    end
    f_q.push_back('{cyc + 1, ref_mem[0]});
    @(negedge clk);
    f_req = 1'b0;
  endtask

  task automatic test_reset_during_return();
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h4;
    #1;
    n_cmp++;
    if (f_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL rst_ret_grant: f_gnt=%b, required 1", f_gnt);
    end
    @(negedge clk);
    f_req = 1'b0; reset = 1'b1;
    #1;
    n_cmp++;
    if (f_valid !== 1'b0 || l_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ret_in_reset: f_valid=%b l_valid=%b, required 0/0", f_valid, l_valid);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++;
      if (f_valid !== 1'b0 || l_valid !== 1'b0 || f_rdata !== 32'h0 || l_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL rst_ret_after %0d: valid=%b%b rdata=%h/%h, required 0/0 and 0/0",
                 i, f_valid, l_valid, f_rdata, l_rdata);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA500_0001 + i * 32'h0001_0203;
      ref_mem[i] = 32'hA500_0001 + i * 32'h0001_0203;
    end
    fa[0] = 32'h0; fa[1] = 32'h4; fa[2] = 32'h8; fa[3] = 32'h7;
    test_reset();
    test_fetch_stream();
    test_starvation();
    test_locked_burst();
    test_reset_during_return();
    @(negedge clk); #3;
    n_cmp++;
    if (f_q.size() != 0 || l_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_returns: f=%0d l=%0d pending, required 0/0", f_q.size(), l_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
